// File: rtl/wide_adder_seq.sv
// wide_adder_seq: multi-word add/subtract sequencer. One 16-bit adder is reused
// each cycle, least-significant word first, with the carry chained through a register.

module adder_16bit (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic        i_cin,
   output logic [15:0] o_y,
   output logic        o_cout,
   output logic        o_zero,
   output logic        o_ovf
);
   assign {o_cout, o_y} = {1'b0, i_a} + {1'b0, i_b} + {16'b0, i_cin};
   assign o_zero        = (o_y == 16'b0);
   assign o_ovf         = (i_a[15] == i_b[15]) && (o_y[15] != i_a[15]);
endmodule

module wide_adder_seq #(
   parameter int WORDS = 4,
   localparam int W    = 16 * WORDS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         op_sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         sign,
   output logic         zero,
   output logic         carry,
   output logic         parity,
   output logic         overflow,
   output logic         busy,
   output logic [1:0]   dbg_state
);
   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // in_ready is high only in IDLE, out_valid only in DONE, and data is held until the transfer.
   localparam int IDXW = $clog2(WORDS);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t          r_state, w_next;
   logic [W-1:0]    r_a, r_b, r_result;
   logic            r_sub, r_carry, r_zacc;
   logic [IDXW-1:0] r_idx;
   logic            r_sign, r_zero, r_cout, r_parity, r_ovf;

   logic [15:0]     w_a_words [WORDS];
   logic [15:0]     w_b_words [WORDS];
   logic [15:0]     w_a, w_b, w_y;
   logic            w_cout, w_zero, w_ovf, w_last;

   for (genvar g = 0; g < WORDS; g++) begin : g_words
      assign w_a_words[g] = r_a[g*16 +: 16];
      assign w_b_words[g] = r_b[g*16 +: 16];
   end

   assign w_a    = w_a_words[r_idx];
   assign w_b    = w_b_words[r_idx] ^ {16{r_sub}};
   assign w_last = (r_idx == IDXW'(WORDS - 1));

   adder_16bit u_add (
      .i_a    (w_a),
      .i_b    (w_b),
      .i_cin  (r_carry),
      .o_y    (w_y),
      .o_cout (w_cout),
      .o_zero (w_zero),
      .o_ovf  (w_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_next = S_RUN;
         S_RUN:   if (w_last)    w_next = S_DONE;
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_sub    <= 1'b0;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_zacc   <= 1'b0;
         r_result <= '0;
         r_sign   <= 1'b0;
         r_zero   <= 1'b0;
         r_cout   <= 1'b0;
         r_parity <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= op_a;
                  r_b     <= op_b;
                  r_sub   <= op_sub;
                  r_idx   <= '0;
                  r_carry <= op_sub;
                  r_zacc  <= 1'b1;
               end
            end
            S_RUN: begin
               r_carry <= w_cout;
               r_zacc  <= r_zacc & w_zero;
               for (int k = 0; k < WORDS; k++) begin
                  if (r_idx == IDXW'(k)) r_result[k*16 +: 16] <= w_y;
               end
               if (w_last) begin
                  // Lower words are already in r_result; the top word is still on the adder output.
                  r_sign   <= w_y[15];
                  r_ovf    <= w_ovf;
                  r_cout   <= w_cout;
                  r_zero   <= r_zacc & w_zero;
                  r_parity <= ~^{w_y, r_result[W-17:0]};
               end else begin
                  r_idx <= r_idx + IDXW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign dbg_state = r_state;
   assign result    = r_result;
   assign sign      = r_sign;
   assign zero      = r_zero;
   assign carry     = r_cout;
   assign parity    = r_parity;
   assign overflow  = r_ovf;
endmodule

// File: tb/tb_wide_adder_seq.sv
// Self-checking bench for wide_adder_seq (WORDS=4): directed table, randomized ops
// against an arithmetic reference model, handshake and asynchronous reset sequences.

module tb_wide_adder_seq;
   localparam int WORDS = 4;
   localparam int W     = 64;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         op_sub = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         in_ready, out_valid, sign, zero, carry, parity, overflow, busy;
   logic [W-1:0] result;
   logic [1:0]   dbg_state;
   logic [4:0]   w_flags;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        sub;
      logic [63:0] r;
      logic [4:0]  f;   // {carry, zero, sign, overflow, parity}
   } vec_t;

   vec_t vecs [8];

   wide_adder_seq #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .sign      (sign),
      .zero      (zero),
      .carry     (carry),
      .parity    (parity),
      .overflow  (overflow),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   assign w_flags = {carry, zero, sign, overflow, parity};

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference: whole-width arithmetic, no word slicing.
   function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                                 output logic [63:0] r, output logic [4:0] f);
      logic [64:0] full;
      logic        ovf;
      full = sub ? ({1'b0, a} + {1'b0, ~b} + 65'd1) : ({1'b0, a} + {1'b0, b});
      r    = full[63:0];
      if (sub) ovf = (a[63] != b[63]) && (r[63] != a[63]);
      else     ovf = (a[63] == b[63]) && (r[63] != a[63]);
      f = {full[64], (r == 64'd0), r[63], ovf, ~^r};
   endfunction

   task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("idle_timeout", {63'd0, in_ready}, 64'd1);
   endtask

   task automatic run_check(input string name, input logic [63:0] a, input logic [63:0] b,
                            input logic sub, input logic [63:0] exp_r, input logic [4:0] exp_f);
      int lat;
      wait_idle();
      op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      chk({name, "_latency"}, 64'(lat), 64'd4);
      chk({name, "_result"}, result, exp_r);
      chk({name, "_flags"}, {59'd0, w_flags}, {59'd0, exp_f});
      chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk({name, "_ov_clear"}, {63'd0, out_valid}, 64'd0);
      @(negedge clk);
   endtask

   initial begin
      logic [63:0] er, er2;
      logic [4:0]  ef, ef2;
      int          n;

      vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 5'b00000};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 5'b11001};
      vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 5'b00110};
      vecs[3] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 5'b00100};
      vecs[4] = '{64'h1234, 64'h1234, 1'b1, 64'h0, 5'b11001};
      vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 5'b10010};
      vecs[6] = '{64'h0001_0000_0000_0000, 64'h1, 1'b1, 64'h0000_FFFF_FFFF_FFFF, 5'b10001};
      vecs[7] = '{64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0,
                  64'h0000_0001_0000_0000, 5'b10000};

      // Clock/reset
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_flags", {59'd0, w_flags}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++)
         run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].r, vecs[i].f);

      for (int i = 0; i < 25; i++) begin
         logic [63:0] ra, rb;
         logic        rs;
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0: rb = ra;
            1: ra = 64'hFFFF_FFFF_FFFF_FFFF;
            2: rb = 64'h0000_0000_0000_0001;
            default: ;
         endcase
         model(ra, rb, rs, er, ef);
         run_check($sformatf("rnd%0d", i), ra, rb, rs, er, ef);
      end

      // Back-pressure in DONE and ignored requests outside IDLE
      wait_idle();
      op_a = 64'h1111_2222_3333_4444; op_b = 64'h0F0F_F0F0_1234_ABCD; op_sub = 1'b0;
      in_valid = 1'b1;
      model(op_a, op_b, op_sub, er, ef);
      model(64'hAAAA_5555_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, er2, ef2);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; op_a = '1; op_b = '1; op_sub = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      chk("hs_reach_done", {63'd0, out_valid}, 64'd1);
      op_a = 64'hAAAA_5555_0000_FFFF; op_b = 64'h0000_0001_0000_0001; op_sub = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("hs_hold_result", result, er);
         chk("hs_hold_flags", {59'd0, w_flags}, {59'd0, ef});
         chk("hs_hold_in_ready", {63'd0, in_ready}, 64'd0);
         chk("hs_hold_valid", {63'd0, out_valid}, 64'd1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("hs_rel_valid", {63'd0, out_valid}, 64'd0);
      chk("hs_rel_in_ready", {63'd0, in_ready}, 64'd1);
      chk("hs_rel_busy", {63'd0, busy}, 64'd0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("hs_next_accept", {63'd0, busy}, 64'd1);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      chk("hs_next_latency", 64'(n), 64'd4);
      chk("hs_next_result", result, er2);
      chk("hs_next_flags", {59'd0, w_flags}, {59'd0, ef2});
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);

      // Asynchronous reset in the middle of RUN
      wait_idle();
      op_a = 64'hDEAD_BEEF_0000_1111; op_b = 64'h0123_4567_89AB_CDEF; op_sub = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", {63'd0, busy}, 64'd0);
      chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("arst_result", result, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_check("post_rst", 64'h1, 64'h1, 1'b0, 64'h2, 5'b00000);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
